// File: rtl/init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : init_pkg
// Purpose  : Shared types for the RAM window fill engine: pattern-select
//            encoding and FSM state encoding.
// Contents : init_mode_t  - data pattern written into the RAM window
//            init_state_t - engine control states
// Revision : 1.0 - initial release
// ============================================================================
package init_pkg;

  typedef enum logic [1:0] {
    MODE_IDENTITY = 2'd0,
    MODE_CONST    = 2'd1,
    MODE_RAMP     = 2'd2,
    MODE_REVERSE  = 2'd3
  } init_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } init_state_t;

endpackage
`default_nettype wire

// File: rtl/init_datagen.sv
`default_nettype none
// ============================================================================
// Module   : init_datagen
// Purpose  : Combinational write-data generator for the fill engine.
// Ports    : mode   in  2       pattern select (init_mode_t encoding)
//            addr   in  ADDR_W  current (already wrapped) write address
//            idx    in  ADDR_W  write index within the fill, from 0
//            fill   in  DATA_W  constant / seed value
//            wrdata out DATA_W  generated data word
// Revision : 1.0 - initial release
// ============================================================================
module init_datagen
  import init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] fill,
  output logic [DATA_W-1:0] wrdata
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  // addr never exceeds DEPTH-1, so this subtraction cannot underflow
  logic [ADDR_W-1:0] w_rev;
  assign w_rev = C_LAST - addr;

  always_comb begin
    wrdata = '0;
    case (mode)
      MODE_IDENTITY: wrdata = DATA_W'(addr);
      MODE_CONST:    wrdata = fill;
      MODE_RAMP:     wrdata = fill + DATA_W'(idx);
      MODE_REVERSE:  wrdata = DATA_W'(w_rev);
      default:       wrdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/init_engine.sv
`default_nettype none
// ============================================================================
// Module   : init_engine
// Purpose  : Fills a contiguous wrap-around window of a single-port RAM with
//            one of four data patterns, one word per cycle, with write
//            back-pressure (stall) and abort.
// Ports    : clk    in  1         clock, rising edge
//            rst_n  in  1         asynchronous active-low reset
//            en     in  1         start request, sampled while rdy=1
//            rdy    out 1         idle, able to accept en
//            mode   in  2         pattern select, latched on accept
//            base   in  ADDR_W    first address, latched on accept
//            count  in  ADDR_W+1  word count (0 = DEPTH), latched on accept
//            fill   in  DATA_W    constant / seed, latched on accept
//            stall  in  1         RAM not ready, suppresses this write
//            abort  in  1         end the current fill without writing
//            addr   out ADDR_W    write address
//            wrdata out DATA_W    write data
//            wren   out 1         write strobe
//            done   out 1         one-cycle end-of-fill pulse
// Revision : 1.0 - initial release
// ============================================================================
module init_engine
  import init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill,
  input  logic              stall,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_idx;

  logic [ADDR_W:0]   w_count_eff;
  logic [ADDR_W-1:0] w_base_mod;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_in_write;
  logic              w_last;

  // Zero and oversize requests both become a full sweep, so no address is
  // ever written twice within one fill.
  assign w_count_eff = ((count == '0) || (count > C_DEPTH)) ? C_DEPTH : count;

  // r_base is kept below DEPTH and r_idx below DEPTH, so the running address
  // needs at most one subtraction of DEPTH to wrap.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
      assign w_base_mod = base;
      assign w_addr     = r_base + r_idx;
    end else begin : g_wrap
      localparam logic [ADDR_W-1:0] C_DEPTH_LO = ADDR_W'(DEPTH);
      logic [ADDR_W:0] w_sum;
      assign w_base_mod = base % C_DEPTH_LO;
      assign w_sum      = {1'b0, r_base} + {1'b0, r_idx};
      assign w_addr     = (w_sum >= {1'b0, C_DEPTH_LO}) ?
                          (w_sum[ADDR_W-1:0] - C_DEPTH_LO) : w_sum[ADDR_W-1:0];
    end
  endgenerate

  assign w_last = ({1'b0, r_idx} == (r_cnt - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= '0;
      r_base  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_WRITE;
            r_mode  <= mode;
            r_base  <= w_base_mod;
            r_fill  <= fill;
            r_cnt   <= w_count_eff;
            r_idx   <= '0;
          end
        end
        ST_WRITE: begin
          // abort wins over stall and suppresses the write of this cycle
          if (abort) begin
            r_state <= ST_DONE;
          end else if (!stall) begin
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  init_datagen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_datagen (
    .mode  (r_mode),
    .addr  (w_addr),
    .idx   (r_idx),
    .fill  (r_fill),
    .wrdata(w_data)
  );

  // Outputs decode straight from state so an asynchronous reset drops the
  // write strobe without waiting for a clock edge.
  assign w_in_write = (r_state == ST_WRITE);
  assign rdy        = (r_state == ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign wren       = w_in_write && !stall && !abort;
  assign addr       = w_in_write ? w_addr : '0;
  assign wrdata     = w_in_write ? w_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_init_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_init_engine
// Purpose  : Self-checking bench for init_engine. Two instances share the
//            same stimulus: one with DEPTH=256, one with DEPTH=200. Each
//            fill's expected write list is computed from the pattern rules,
//            then consumed one entry per unstalled write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_init_engine;

  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] base;
  logic [8:0] count;
  logic [7:0] fill;
  logic       stall;
  logic       abort;

  logic [1:0] rdy_v;
  logic [1:0] wren_v;
  logic [1:0] done_v;
  logic [7:0] addr_v [2];
  logic [7:0] data_v [2];

  int n_chk = 0;
  int n_err = 0;

  int depth [2] = '{256, 200};
  int ea    [2][256];
  int ed    [2][256];
  int ecnt  [2];
  int ph    [2];   // 0 idle, 1 writing, 2 done pulse
  int pos   [2];
  int donec [2];
  int nwr   [2];

  always #5 clk = ~clk;

  init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy_v[0]), .mode(mode),
    .base(base), .count(count), .fill(fill), .stall(stall), .abort(abort),
    .addr(addr_v[0]), .wrdata(data_v[0]), .wren(wren_v[0]), .done(done_v[0])
  );

  init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy_v[1]), .mode(mode),
    .base(base), .count(count), .fill(fill), .stall(stall), .abort(abort),
    .addr(addr_v[1]), .wrdata(data_v[1]), .wren(wren_v[1]), .done(done_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected write list for one fill on each instance.
  task automatic build(input int m, input int b, input int cnt, input int f);
    for (int d = 0; d < 2; d++) begin
      int dd;
      int e;
      int bb;
      dd = depth[d];
      e  = (cnt == 0 || cnt > dd) ? dd : cnt;
      bb = b % dd;
      ecnt[d] = e;
      for (int k = 0; k < e; k++) begin
        int a;
        a = (bb + k) % dd;
        ea[d][k] = a;
        case (m)
          0:       ed[d][k] = a & 255;
          1:       ed[d][k] = f & 255;
          2:       ed[d][k] = (f + k) & 255;
          default: ed[d][k] = (dd - 1 - a) & 255;
        endcase
      end
    end
  endtask

  task automatic check_cycle(input int c, input logic st, input logic ab);
    for (int d = 0; d < 2; d++) begin
      if (wren_v[d] === 1'b1) nwr[d]++;
      if (ph[d] == 1) begin
        chk($sformatf("wren%0d", d), wren_v[d], !st && !ab);
        chk($sformatf("addr%0d", d), addr_v[d], ea[d][pos[d]]);
        chk($sformatf("data%0d", d), data_v[d], ed[d][pos[d]]);
        chk($sformatf("rdy%0d", d), rdy_v[d], 0);
        chk($sformatf("done%0d", d), done_v[d], 0);
        if (ab) ph[d] = 2;
        else if (!st) begin
          pos[d]++;
          if (pos[d] == ecnt[d]) ph[d] = 2;
        end
      end else if (ph[d] == 2) begin
        chk($sformatf("done%0d", d), done_v[d], 1);
        chk($sformatf("rdy%0d", d), rdy_v[d], 0);
        chk($sformatf("wren%0d", d), wren_v[d], 0);
        chk($sformatf("addr%0d", d), addr_v[d], 0);
        chk($sformatf("data%0d", d), data_v[d], 0);
        donec[d] = c;
        ph[d] = 0;
      end else begin
        chk($sformatf("idle_rdy%0d", d), rdy_v[d], 1);
        chk($sformatf("idle_done%0d", d), done_v[d], 0);
        chk($sformatf("idle_wren%0d", d), wren_v[d], 0);
        chk($sformatf("idle_addr%0d", d), addr_v[d], 0);
        chk($sformatf("idle_data%0d", d), data_v[d], 0);
      end
    end
  endtask

  // s_lo..s_hi: forced stall cycles; ab_c: abort cycle; rst_c: async reset
  // cycle; exp_d0/exp_d1: expected done cycle per instance (-1 = unchecked).
  task automatic run_fill(input int m, input int b, input int cnt, input int f,
                          input int stall_pct, input int s_lo, input int s_hi,
                          input int ab_c, input int rst_c,
                          input int exp_d0, input int exp_d1);
    int   c;
    logic st;
    logic ab;
    bit   quit;
    build(m, b, cnt, f);
    nwr[0] = 0; nwr[1] = 0;
    donec[0] = -1; donec[1] = -1;
    @(posedge clk); #1;
    en = 1'b1; mode = 2'(m); base = 8'(b); count = 9'(cnt); fill = 8'(f);
    stall = 1'($urandom_range(1)); abort = 1'($urandom_range(1));
    @(negedge clk);
    check_cycle(0, stall, abort);
    ph[0] = 1; ph[1] = 1; pos[0] = 0; pos[1] = 0;
    c = 1;
    quit = 0;
    while ((ph[0] != 0 || ph[1] != 0) && c < LIMIT && !quit) begin
      @(posedge clk); #1;
      en    = (ph[0] != 0 && ph[1] != 0) ? 1'($urandom_range(3) == 0) : 1'b0;
      mode  = 2'($urandom); base = 8'($urandom); fill = 8'($urandom);
      count = 9'($urandom);
      st    = (c >= s_lo && c <= s_hi) || ($urandom_range(99) < stall_pct);
      ab    = (c == ab_c);
      stall = st; abort = ab;
      if (c == rst_c) begin
        #2 rst_n = 1'b0;
        #1;
        ph[0] = 0; ph[1] = 0;
        check_cycle(c, st, ab);
        en = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        quit = 1;
      end else begin
        @(negedge clk);
        check_cycle(c, st, ab);
        c++;
      end
    end
    chk("timeout", (c < LIMIT), 1);
    en = 1'b0; stall = 1'b0; abort = 1'b0;
    if (exp_d0 >= 0) chk("done_cyc0", donec[0], exp_d0);
    if (exp_d1 >= 0) chk("done_cyc1", donec[1], exp_d1);
    if (ab_c < 0 && rst_c < 0) begin
      chk("nwr0", nwr[0], ecnt[0]);
      chk("nwr1", nwr[1], ecnt[1]);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = '0; base = '0; count = '0; fill = '0;
    stall = 1'b0; abort = 1'b0;
    ph[0] = 0; ph[1] = 0;
    #12;
    check_cycle(0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_cycle(0, 1'b0, 1'b0);

    // full identity sweep, count=0 means DEPTH
    run_fill(0, 0, 0, 0, 0, -1, -1, -1, -1, 257, 201);
    // constant fill wrapping past the top of the RAM
    run_fill(1, 250, 10, 'hA5, 0, -1, -1, -1, -1, 11, 11);
    // ramp with stalls on cycles 2-3
    run_fill(2, 4, 4, 'hFE, 0, 2, 3, -1, -1, 7, 7);
    // reverse with oversize count clamped
    run_fill(3, 0, 300, 0, 0, -1, -1, -1, -1, 257, 201);
    // abort on the 6th write cycle
    run_fill(2, 30, 20, 'h11, 0, -1, -1, 6, -1, 7, 7);
    // asynchronous reset mid-fill, then a fresh fill from idx 0
    run_fill(2, 100, 50, 'h40, 20, -1, -1, -1, 10, -1, -1);
    run_fill(2, 7, 5, 'h80, 0, -1, -1, -1, -1, 6, 6);

    for (int i = 0; i < 25; i++) begin
      int ab_c;
      ab_c = ($urandom_range(3) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_fill(int'($urandom_range(3)), int'($urandom_range(255)),
               int'($urandom_range(300)), int'($urandom_range(255)),
               int'($urandom_range(40)), -1, -1, ab_c, -1, -1, -1);
    end

    @(negedge clk);
    check_cycle(0, stall, abort);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
